// File: rtl/lif_membrane_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : lif_membrane_integrator
//  Description : Leaky integrate-and-fire neuron core wrapped around an
//                external 16-bit signed adder. Holds a saturating membrane
//                potential, leaks on each timestep tick, thresholds, emits a
//                one-cycle spike and enforces a refractory period.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_membrane_integrator #(
    parameter logic signed [15:0] THRESHOLD    = 16'sd1000,
    parameter logic signed [15:0] V_RESET      = 16'sd0,
    parameter int                 LEAK_SHIFT   = 4,
    parameter int                 REFRAC_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               in_valid,
    input  logic signed [15:0] in_weight,
    output logic               in_ready,
    output logic signed [15:0] alu_x,
    output logic signed [15:0] alu_y,
    input  logic signed [15:0] alu_z,
    input  logic               alu_overflow,
    output logic signed [15:0] membrane,
    output logic               spike_out,
    output logic               refrac_active,
    output logic [15:0]        spike_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAK  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam logic [15:0] c_REFRAC_LOAD = 16'(REFRAC_TICKS);

    state_t             state_q, state_d;
    logic signed [15:0] membrane_q, membrane_d;
    logic [15:0]        refrac_q, refrac_d;
    logic [15:0]        count_q, count_d;
    logic               spike_q, spike_d;

    logic signed [15:0] w_sat;
    logic signed [15:0] w_leak;

    // Saturate the adder sum: a wrapped sign bit tells which rail was crossed.
    always_comb begin
        w_sat = alu_z;
        if (alu_overflow) begin
            w_sat = alu_z[15] ? 16'sh7FFF : 16'sh8000;
        end
    end

    // Leak magnitude; negation is safe since the shift leaves headroom.
    assign w_leak = membrane_q >>> LEAK_SHIFT;

    // Next-state, adder operand and handshake decode.
    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        refrac_d   = refrac_q;
        count_d    = count_q;
        spike_d    = 1'b0;
        alu_y      = 16'sd0;
        in_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !tick && !rst;
                alu_y    = in_weight;
                if (tick) begin
                    state_d = LEAK;
                end else if (in_valid && (refrac_q == 16'd0)) begin
                    // Refractory inputs are consumed but never integrated.
                    membrane_d = w_sat;
                end
            end
            LEAK: begin
                if (refrac_q != 16'd0) begin
                    refrac_d = refrac_q - 16'd1;
                    state_d  = IDLE;
                end else begin
                    alu_y      = -w_leak;
                    membrane_d = w_sat;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (membrane_q >= THRESHOLD) begin
                    membrane_d = V_RESET;
                    refrac_d   = c_REFRAC_LOAD;
                    spike_d    = 1'b1;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any in-flight leak/check and pending spike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            membrane_q <= 16'sd0;
            refrac_q   <= 16'd0;
            count_q    <= 16'd0;
            spike_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            membrane_q <= membrane_d;
            refrac_q   <= refrac_d;
            count_q    <= count_d;
            spike_q    <= spike_d;
        end
    end

    assign alu_x         = membrane_q;
    assign membrane      = membrane_q;
    assign spike_out     = spike_q;
    assign refrac_active = (refrac_q != 16'd0);
    assign spike_count   = count_q;

endmodule
`default_nettype wire

// File: doc/lif_membrane_integrator.md
Name: lif_membrane_integrator

Overview:
- Sequential leaky integrate-and-fire neuron core. It sits directly around the 16-bit signed adder stage.
- Drives the adder operands (membrane potential plus a weighted input or a leak term) and consumes the adder's sum and overflow flag.
- Holds the registered, saturating membrane potential; applies leak on each timestep tick; thresholds; emits spikes; enforces a refractory period.
- Feeds the spike router downstream.

Parameters:
- THRESHOLD, 16'sd1000, signed firing threshold; fire when membrane >= THRESHOLD.
- V_RESET, 16'sd0, signed membrane value loaded after a spike.
- LEAK_SHIFT, 4, leak = membrane >>> LEAK_SHIFT (arithmetic shift); legal range 1..15.
- REFRAC_TICKS, 2, number of ticks the neuron ignores input after a spike; 0 disables the refractory period.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- tick  input  1  timestep boundary pulse
- in_valid  input  1  weighted synaptic input valid
- in_weight  input  16  signed synaptic weight
- in_ready  output  1  input accepted when in_valid && in_ready
- alu_x  output  16  adder operand X = membrane (combinational)
- alu_y  output  16  adder operand Y (combinational, per state)
- alu_z  input  16  adder sum
- alu_overflow  input  1  adder signed-overflow flag
- membrane  output  16  signed membrane potential (registered)
- spike_out  output  1  one-cycle spike pulse (registered)
- refrac_active  output  1  high while refractory count is nonzero
- spike_count  output  16  saturating count of spikes since reset

Behaviour:
- Reset (asynchronous, active-high), all outputs and state cleared:
  - membrane=0, spike_out=0, spike_count=0, refractory count=0, state=IDLE.
  - in_ready=0 while rst is high.
- Saturation rule, applied to every membrane write from alu_z:
  - if alu_overflow && alu_z[15]: write 16'sh7FFF (positive overflow).
  - if alu_overflow && !alu_z[15]: write 16'sh8000 (negative overflow).
  - otherwise write alu_z.
- States: IDLE, LEAK, CHECK.
- IDLE:
  - in_ready = !tick (combinational).
  - alu_y = in_weight.
  - Input accepted (in_valid && in_ready) with refractory count 0: membrane <= sat(alu_z).
  - Input accepted with refractory count > 0: input consumed and discarded; membrane unchanged.
  - tick high: next state LEAK; any in_valid that cycle is not accepted and must be held by the upstream.
- LEAK (1 cycle):
  - in_ready=0.
  - Refractory count > 0: decrement it, membrane unchanged, next state IDLE (no check).
  - Refractory count 0: alu_y = -(membrane >>> LEAK_SHIFT), membrane <= sat(alu_z), next state CHECK.
- CHECK (1 cycle):
  - in_ready=0.
  - membrane >= THRESHOLD (signed compare): membrane <= V_RESET; refractory count <= REFRAC_TICKS; spike_out registered high the following cycle for exactly 1 cycle; spike_count increments, holding at 16'hFFFF.
  - Next state IDLE either way.
- Operand outside the active cases: alu_y = 0 when not in IDLE and not doing a leak.
- Latency: tick sampled in cycle T -> LEAK at T+1 -> CHECK at T+2 -> spike_out high during T+3.
- Threshold checks happen only on tick, never on input accept.
- Negating the leak term cannot overflow because LEAK_SHIFT >= 1.
- A tick arriving while in LEAK or CHECK is ignored; the upstream guarantees ticks are at least 4 cycles apart.
- refrac_active = (refractory count != 0).
- Reset asserted in any state aborts the operation immediately: a pending spike is dropped and all values return to their reset values.

Test Plan:
- Defaults; accept weights 300,300,300,200, then tick -> membrane 1100, leak 68 -> 1032; spike_out high at T+3; membrane=0; spike_count=1; refrac_active=1.
- membrane 32000, input 1000 (alu_overflow=1, alu_z negative) -> membrane 32767; from -32000, input -1000 -> membrane -32768.
- Leak of -32768 on tick -> +2048 added -> membrane -30720; no spike.
- After a spike: input 500 accepted but discarded (membrane stays 0); tick -> refrac 1; tick -> refrac 0, refrac_active=0; input 500 -> membrane 500.
- tick and in_valid together in IDLE -> in_ready=0, weight not added; weight held and accepted in the first IDLE cycle after CHECK.
- rst pulsed during CHECK with membrane 1200 -> no spike_out, membrane=0, state IDLE, spike_count unchanged at 0.
